// File: rtl/gru_dense_output_layer.sv
// Serial fully connected readout after the GRU layer: y[o] = sum_j W[o][j]*h[j] + b[o].
// One signed fixed-point MAC per cycle; level-held start/done handshake.
module gru_dense_output_layer #(
    parameter int DATA_WIDTH  = 32,
    parameter int GRU_UNITS   = 3,
    parameter int OUTPUT_SIZE = 1,
    parameter int FRAC_BITS   = 16
) (
    input  logic                                          clk,
    input  logic                                          rstn,
    input  logic                                          i_start,
    output logic                                          o_done,
    output logic                                          o_busy,
    output logic                                          o_overflow,
    input  logic [GRU_UNITS*DATA_WIDTH-1:0]               i_hidden_state_flat,
    input  logic [OUTPUT_SIZE*GRU_UNITS*DATA_WIDTH-1:0]   i_W_flat,
    input  logic [OUTPUT_SIZE*DATA_WIDTH-1:0]             i_b_flat,
    output logic [OUTPUT_SIZE*DATA_WIDTH-1:0]             o_output_flat
);

    // state | meaning
    // IDLE  | waiting for i_start
    // LOAD  | snapshot hidden vector, clear indices and accumulator
    // MAC   | one product per cycle for current neuron
    // BIAS  | add bias, saturate, stage y[o]
    // DONE  | results published, wait for i_start to drop
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_MAC  = 3'd2;
    localparam logic [2:0] S_BIAS = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int DW = DATA_WIDTH;
    localparam int AW = 2 * DATA_WIDTH;
    localparam int JW = (GRU_UNITS > 1) ? $clog2(GRU_UNITS) : 1;
    localparam int OW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
    localparam logic [JW-1:0] J_LAST = JW'(GRU_UNITS - 1);
    localparam logic [OW-1:0] O_LAST = OW'(OUTPUT_SIZE - 1);
    localparam logic signed [AW-1:0] SAT_MAX = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic [2:0]                    state;
    logic [GRU_UNITS*DW-1:0]       h_snap;
    logic signed [AW-1:0]          acc;
    logic [JW-1:0]                 j_idx;
    logic [OW-1:0]                 o_idx;
    logic [OUTPUT_SIZE*DW-1:0]     staging;
    logic [OUTPUT_SIZE*DW-1:0]     staging_next;
    logic [DW-1:0]                 w_cur;
    logic [DW-1:0]                 h_cur;
    logic [DW-1:0]                 b_cur;
    logic [DW-1:0]                 y_sat;
    logic signed [AW-1:0]          prod;
    logic signed [AW-1:0]          acc_mac;
    logic signed [AW-1:0]          sum;
    logic                          clamp;

    always_comb begin
        w_cur = i_W_flat[(int'(o_idx) * GRU_UNITS + int'(j_idx)) * DW +: DW];
        h_cur = h_snap[int'(j_idx) * DW +: DW];
        b_cur = i_b_flat[int'(o_idx) * DW +: DW];
        // Low AW bits of the product of sign-extended operands equal the signed product.
        prod    = $signed({{DW{w_cur[DW-1]}}, w_cur} * {{DW{h_cur[DW-1]}}, h_cur});
        acc_mac = acc + (prod >>> FRAC_BITS);
        sum     = acc + $signed({{DW{b_cur[DW-1]}}, b_cur});
        clamp   = 1'b0;
        y_sat   = sum[DW-1:0];
        if (sum > SAT_MAX) begin
            clamp = 1'b1;
            y_sat = {1'b0, {(DW-1){1'b1}}};
        end else if (sum < SAT_MIN) begin
            clamp = 1'b1;
            y_sat = {1'b1, {(DW-1){1'b0}}};
        end
        staging_next = staging;
        staging_next[int'(o_idx) * DW +: DW] = y_sat;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_IDLE;
            o_done        <= 1'b0;
            o_busy        <= 1'b0;
            o_overflow    <= 1'b0;
            o_output_flat <= '0;
            h_snap        <= '0;
            acc           <= '0;
            j_idx         <= '0;
            o_idx         <= '0;
            staging       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        state      <= S_LOAD;
                        o_overflow <= 1'b0;
                        o_busy     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    h_snap <= i_hidden_state_flat;
                    o_idx  <= '0;
                    j_idx  <= '0;
                    acc    <= '0;
                    state  <= S_MAC;
                end
                S_MAC: begin
                    acc <= acc_mac;
                    if (j_idx == J_LAST) begin
                        state <= S_BIAS;
                    end else begin
                        j_idx <= j_idx + JW'(1);
                    end
                end
                S_BIAS: begin
                    staging <= staging_next;
                    if (clamp) begin
                        o_overflow <= 1'b1;
                    end
                    if (o_idx == O_LAST) begin
                        o_output_flat <= staging_next;
                        o_done        <= 1'b1;
                        o_busy        <= 1'b0;
                        state         <= S_DONE;
                    end else begin
                        o_idx <= o_idx + OW'(1);
                        j_idx <= '0;
                        acc   <= '0;
                        state <= S_MAC;
                    end
                end
                S_DONE: begin
                    if (!i_start) begin
                        o_done <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gru_dense_output_layer.sv
// Bench for gru_dense_output_layer: a 1-output and a 2-output instance checked
// against a plain-arithmetic reference of the dense layer.
module tb_gru_dense_output_layer;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic         start1, done1, busy1, ovf1;
    logic [95:0]  hflat1, wflat1;
    logic [31:0]  bflat1, y1;

    logic         start2, done2, busy2, ovf2;
    logic [95:0]  hflat2;
    logic [191:0] wflat2;
    logic [63:0]  bflat2, y2;

    gru_dense_output_layer #(.DATA_WIDTH(32), .GRU_UNITS(3), .OUTPUT_SIZE(1), .FRAC_BITS(16)) u_dut1 (
        .clk(clk), .rstn(rstn), .i_start(start1), .o_done(done1), .o_busy(busy1),
        .o_overflow(ovf1), .i_hidden_state_flat(hflat1), .i_W_flat(wflat1),
        .i_b_flat(bflat1), .o_output_flat(y1)
    );

    gru_dense_output_layer #(.DATA_WIDTH(32), .GRU_UNITS(3), .OUTPUT_SIZE(2), .FRAC_BITS(16)) u_dut2 (
        .clk(clk), .rstn(rstn), .i_start(start2), .o_done(done2), .o_busy(busy2),
        .o_overflow(ovf2), .i_hidden_state_flat(hflat2), .i_W_flat(wflat2),
        .i_b_flat(bflat2), .o_output_flat(y2)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference neuron: floor-shifted products summed exactly, bias added, then clamped.
    function automatic logic [31:0] ref_neuron(input int hv[3], input int wv[3], input int bv,
                                               output bit ovf);
        longint acc;
        longint s;
        acc = 0;
        for (int j = 0; j < 3; j++) acc += (longint'(wv[j]) * longint'(hv[j])) >>> 16;
        s = acc + longint'(bv);
        ovf = 1'b0;
        if (s > 64'sd2147483647) begin
            ovf = 1'b1;
            return 32'h7FFF_FFFF;
        end
        if (s < -64'sd2147483648) begin
            ovf = 1'b1;
            return 32'h8000_0000;
        end
        return s[31:0];
    endfunction

    function automatic logic [95:0] pack3(input int v[3]);
        return {v[2], v[1], v[0]};
    endfunction

    // lat = edges after the sampling edge until done is seen; -1 if never.
    task automatic run1(input bit corrupt_h, output int lat);
        @(negedge clk);
        start1 = 1'b1;
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                chk("busy1_mid", busy1, 1);
                if (corrupt_h) hflat1 = {$urandom, $urandom, $urandom};
            end
            if (done1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic release1();
        @(negedge clk);
        start1 = 1'b0;
        @(posedge clk); #1;
        chk("done1_drop", done1, 0);
    endtask

    task automatic run2(output int lat);
        @(negedge clk);
        start2 = 1'b1;
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (n == 1) chk("busy2_mid", busy2, 1);
            if (done2) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic release2();
        @(negedge clk);
        start2 = 1'b0;
        @(posedge clk); #1;
        chk("done2_drop", done2, 0);
    endtask

    int h[3], w[3], wa[3], wb[3];
    int b, b0, b1;
    int lat;
    bit o0, o1;
    logic [31:0] e0, e1;

    initial begin
        start1 = 0; start2 = 0;
        hflat1 = '0; wflat1 = '0; bflat1 = '0;
        hflat2 = '0; wflat2 = '0; bflat2 = '0;
        #12;
        chk("rst_done", done1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_ovf", ovf1, 0);
        chk("rst_y", y1, 0);
        chk("rst_y2", y2, 0);
        @(negedge clk);
        rstn = 1'b1;

        // Nominal default case
        h = '{32'h0001_0000, 32'h0002_0000, 32'hFFFF_0000};
        w = '{32'h0000_8000, 32'h0000_4000, 32'h0001_0000};
        b = 32'h0000_2000;
        hflat1 = pack3(h); wflat1 = pack3(w); bflat1 = b;
        run1(0, lat);
        chk("nom_lat", lat, 5);
        chk("nom_y", y1, 32'h0000_2000);
        chk("nom_y_model", y1, ref_neuron(h, w, b, o0));
        chk("nom_ovf", ovf1, 0);
        chk("nom_busy_done", busy1, 0);
        @(posedge clk); #1;
        chk("nom_done_held", done1, 1);
        release1();

        // Two outputs
        hflat2 = pack3(h);
        wa = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
        wb = '{0, 0, 0};
        wflat2 = {pack3(wb), pack3(wa)};
        bflat2 = {32'hFFFF_0000, 32'h0000_0000};
        run2(lat);
        chk("two_lat", lat, 9);
        chk("two_y0", y2[31:0], 32'h0002_0000);
        chk("two_y1", y2[63:32], 32'hFFFF_0000);
        chk("two_ovf", ovf2, 0);
        release2();

        // Positive and negative saturation
        h = '{32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000};
        w = '{32'h0002_0000, 32'h0002_0000, 32'h0002_0000};
        b = 0;
        hflat1 = pack3(h); wflat1 = pack3(w); bflat1 = b;
        run1(0, lat);
        chk("satp_lat", lat, 5);
        chk("satp_y", y1, 32'h7FFF_FFFF);
        chk("satp_ovf", ovf1, 1);
        release1();
        w = '{32'hFFFE_0000, 32'hFFFE_0000, 32'hFFFE_0000};
        wflat1 = pack3(w);
        run1(0, lat);
        chk("satn_y", y1, 32'h8000_0000);
        chk("satn_ovf", ovf1, 1);
        release1();
        repeat (3) @(posedge clk);
        #1 chk("ovf_held_idle", ovf1, 1);
        chk("y_held_idle", y1, 32'h8000_0000);
        h = '{32'h0001_0000, 32'h0002_0000, 32'hFFFF_0000};
        w = '{32'h0000_8000, 32'h0000_4000, 32'h0001_0000};
        b = 32'h0000_2000;
        hflat1 = pack3(h); wflat1 = pack3(w); bflat1 = b;
        run1(0, lat);
        chk("benign_ovf", ovf1, 0);
        chk("benign_y", y1, 32'h0000_2000);
        release1();

        // Floor rounding of a negative product
        h = '{32'hFFFF_FFFF, 0, 0};
        w = '{32'h0000_8000, 0, 0};
        b = 0;
        hflat1 = pack3(h); wflat1 = pack3(w); bflat1 = b;
        run1(0, lat);
        chk("floor_y", y1, 32'hFFFF_FFFF);
        release1();

        // Snapshot: hidden input scrambled after LOAD; then long start hold
        for (int j = 0; j < 3; j++) begin
            h[j] = int'($urandom) >>> 8;
            w[j] = int'($urandom) >>> 10;
        end
        b = int'($urandom) >>> 4;
        hflat1 = pack3(h); wflat1 = pack3(w); bflat1 = b;
        e0 = ref_neuron(h, w, b, o0);
        run1(1, lat);
        chk("snap_lat", lat, 5);
        chk("snap_y", y1, e0);
        chk("snap_ovf", ovf1, o0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("hold_done", done1, 1);
            chk("hold_busy", busy1, 0);
            chk("hold_y", y1, e0);
        end
        release1();

        // Reset during MAC
        h = '{32'h0001_0000, 32'h0002_0000, 32'hFFFF_0000};
        w = '{32'h0000_8000, 32'h0000_4000, 32'h0001_0000};
        b = 32'h0000_2000;
        hflat1 = pack3(h); wflat1 = pack3(w); bflat1 = b;
        @(negedge clk);
        start1 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rmid_y", y1, 0);
        chk("rmid_done", done1, 0);
        chk("rmid_busy", busy1, 0);
        chk("rmid_ovf", ovf1, 0);
        chk("rmid_y2", y2, 0);
        start1 = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        run1(0, lat);
        chk("rpost_lat", lat, 5);
        chk("rpost_y", y1, 32'h0000_2000);
        release1();

        // Randomized two-output runs against the reference
        for (int it = 0; it < 12; it++) begin
            for (int j = 0; j < 3; j++) begin
                h[j]  = int'($urandom) >>> $urandom_range(4, 16);
                wa[j] = int'($urandom) >>> $urandom_range(4, 16);
                wb[j] = int'($urandom) >>> $urandom_range(4, 16);
            end
            b0 = int'($urandom) >>> $urandom_range(0, 8);
            b1 = int'($urandom) >>> $urandom_range(0, 8);
            hflat2 = pack3(h);
            wflat2 = {pack3(wb), pack3(wa)};
            bflat2 = {b1, b0};
            e0 = ref_neuron(h, wa, b0, o0);
            e1 = ref_neuron(h, wb, b1, o1);
            run2(lat);
            chk("rnd_lat", lat, 9);
            chk("rnd_y0", y2[31:0], e0);
            chk("rnd_y1", y2[63:32], e1);
            chk("rnd_ovf", ovf2, o0 | o1);
            release2();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
